// File: rtl/gpio_irq_if.sv
// Device-bus bundle: single-cycle request, registered response one cycle later.
interface gpio_irq_if;
  logic        device_req;
  logic [31:0] device_addr;
  logic        device_we;
  logic [3:0]  device_be;
  logic [31:0] device_wdata;
  logic        device_rvalid;
  logic [31:0] device_rdata;

  modport master (
    output device_req, device_addr, device_we, device_be, device_wdata,
    input  device_rvalid, device_rdata
  );

  modport slave (
    input  device_req, device_addr, device_we, device_be, device_wdata,
    output device_rvalid, device_rdata
  );
endinterface

// File: rtl/gpio_irq.sv
// Edge-detect interrupt controller for debounced GPIO inputs: sticky edge
// flags, per-line enables, single registered level interrupt.
module gpio_irq #(
  parameter int unsigned GpiWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gpio_irq_if.slave           bus_if,
  input  logic [GpiWidth-1:0] gp_dbnc_i,
  output logic                irq_o
);

  localparam logic [11:0] OffState  = 12'h000;
  localparam logic [11:0] OffEnable = 12'h004;
  localparam logic [11:0] OffRise   = 12'h008;
  localparam logic [11:0] OffFall   = 12'h00C;
  localparam logic [11:0] OffTest   = 12'h010;
  localparam logic [11:0] OffPrev   = 12'h014;

  logic [GpiWidth-1:0] state_q, state_d;
  logic [GpiWidth-1:0] enable_q, enable_d;
  logic [GpiWidth-1:0] rise_en_q, rise_en_d;
  logic [GpiWidth-1:0] fall_en_q, fall_en_d;
  logic [GpiWidth-1:0] prev_q;
  logic                primed_q;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic [31:0]         be_mask;
  logic [GpiWidth-1:0] wmask, wbits;
  logic [GpiWidth-1:0] w1c_clear, test_wr;
  logic [GpiWidth-1:0] rise, fall, set_bits;
  logic [11:0]         offset;
  logic                wr_en, rd_en;
  logic                unused_bits;

  for (genvar gi = 0; gi < 4; gi++) begin : g_be_mask
    assign be_mask[8*gi +: 8] = {8{bus_if.device_be[gi]}};
  end

  assign offset = bus_if.device_addr[11:0];
  assign wr_en  = bus_if.device_req & bus_if.device_we;
  assign rd_en  = bus_if.device_req & ~bus_if.device_we;
  assign wmask  = be_mask[GpiWidth-1:0];
  // Disabled byte lanes contribute zeros, which is what W1C/W1S need.
  assign wbits  = bus_if.device_wdata[GpiWidth-1:0] & wmask;
  assign unused_bits = ^{bus_if.device_addr[31:12], bus_if.device_wdata, be_mask};

  assign rise     = {GpiWidth{primed_q}} & gp_dbnc_i & ~prev_q;
  assign fall     = {GpiWidth{primed_q}} & ~gp_dbnc_i & prev_q;
  assign set_bits = (rise & rise_en_q) | (fall & fall_en_q) | test_wr;

  always_comb begin
    enable_d  = enable_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_clear = '0;
    test_wr   = '0;
    if (wr_en) begin
      case (offset)
        OffState:  w1c_clear = wbits;
        OffEnable: enable_d  = (enable_q & ~wmask) | wbits;
        OffRise:   rise_en_d = (rise_en_q & ~wmask) | wbits;
        OffFall:   fall_en_d = (fall_en_q & ~wmask) | wbits;
        OffTest:   test_wr   = wbits;
        default:   ;
      endcase
    end
    // A fresh edge beats a simultaneous clear so no event is ever lost.
    state_d = (state_q & ~w1c_clear) | set_bits;
    irq_d   = |(state_d & enable_d);
  end

  always_comb begin
    rvalid_d = bus_if.device_req;
    rdata_d  = '0;
    if (rd_en) begin
      case (offset)
        OffState:  rdata_d = 32'(state_q);
        OffEnable: rdata_d = 32'(enable_q);
        OffRise:   rdata_d = 32'(rise_en_q);
        OffFall:   rdata_d = 32'(fall_en_q);
        OffPrev:   rdata_d = 32'(prev_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= '0;
      enable_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      prev_q    <= gp_dbnc_i;
      primed_q  <= 1'b1;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus_if.device_rvalid = rvalid_q;
  assign bus_if.device_rdata  = rdata_q;
  assign irq_o                = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed, table-driven bench for gpio_irq: one record per clock cycle,
// expectations are the outputs registered at the end of that cycle.
module tb_gpio_irq;

  localparam int W = 16;

  typedef struct {
    bit          rst;
    bit          req;
    bit          we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [W-1:0] gpi;
    bit          exp_rvalid;
    logic [31:0] exp_rdata;
    bit          exp_irq;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gp_dbnc;
  logic         irq;
  int           applied = 0;
  int           miscompares = 0;
  vec_t         vecs[$];

  gpio_irq_if bus_if ();

  gpio_irq #(.GpiWidth(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus_if    (bus_if.slave),
    .gp_dbnc_i (gp_dbnc),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit rq, bit w, logic [11:0] a, logic [3:0] b,
                              logic [31:0] d, logic [W-1:0] g, logic [31:0] er, bit ei);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.addr = a; v.be = b; v.wdata = d; v.gpi = g;
    v.exp_rvalid = rq & ~r;
    v.exp_rdata  = er;
    v.exp_irq    = ei;
    return v;
  endfunction

  function automatic vec_t rs(logic [W-1:0] g);
    return mk(1, 0, 0, 12'h0, 4'h0, 32'h0, g, 32'h0, 0);
  endfunction
  function automatic vec_t wr(logic [11:0] a, logic [3:0] b, logic [31:0] d,
                              logic [W-1:0] g, bit ei);
    return mk(0, 1, 1, a, b, d, g, 32'h0, ei);
  endfunction
  function automatic vec_t rd(logic [11:0] a, logic [W-1:0] g, logic [31:0] er, bit ei);
    return mk(0, 1, 0, a, 4'h0, 32'h0, g, er, ei);
  endfunction
  function automatic vec_t idle(logic [W-1:0] g, bit ei);
    return mk(0, 0, 0, 12'h0, 4'h0, 32'h0, g, 32'h0, ei);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    rst                 = v.rst;
    bus_if.device_req   = v.req;
    bus_if.device_we    = v.we;
    bus_if.device_addr  = {20'h0, v.addr};
    bus_if.device_be    = v.be;
    bus_if.device_wdata = v.wdata;
    gp_dbnc             = v.gpi;
    @(posedge clk);
    #1;
    applied++;
    if (bus_if.device_rvalid !== v.exp_rvalid) begin
      miscompares++;
      $display("FAIL vec%0d rvalid: got %0b expected %0b", idx, bus_if.device_rvalid, v.exp_rvalid);
    end
    if (bus_if.device_rdata !== v.exp_rdata) begin
      miscompares++;
      $display("FAIL vec%0d rdata: got %08h expected %08h", idx, bus_if.device_rdata, v.exp_rdata);
    end
    if (irq !== v.exp_irq) begin
      miscompares++;
      $display("FAIL vec%0d irq: got %0b expected %0b", idx, irq, v.exp_irq);
    end
    $display("vec%0d rst=%0b req=%0b we=%0b addr=%03h be=%h wdata=%08h gpi=%04h -> rvalid=%0b rdata=%08h irq=%0b",
             idx, v.rst, v.req, v.we, v.addr, v.be, v.wdata, v.gpi,
             bus_if.device_rvalid, bus_if.device_rdata, irq);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.device_req = 1'b0; bus_if.device_we = 1'b0; bus_if.device_addr = '0;
    bus_if.device_be = '0; bus_if.device_wdata = '0; gp_dbnc = '0;

    // Rising edge on bit 0, then W1C clear.
    vecs.push_back(rs('h00));
    vecs.push_back(wr(12'h008, 4'hF, 32'h01, 'h00, 0));
    vecs.push_back(wr(12'h004, 4'hF, 32'h01, 'h00, 0));
    vecs.push_back(idle('h01, 1));
    vecs.push_back(rd(12'h000, 'h01, 32'h01, 1));
    vecs.push_back(wr(12'h000, 4'hF, 32'h01, 'h01, 0));
    vecs.push_back(rd(12'h000, 'h01, 32'h00, 0));
    // Falling-only on bit 7.
    vecs.push_back(wr(12'h008, 4'hF, 32'h00, 'h01, 0));
    vecs.push_back(wr(12'h00C, 4'hF, 32'h80, 'h01, 0));
    vecs.push_back(wr(12'h004, 4'hF, 32'h80, 'h01, 0));
    vecs.push_back(idle('h81, 0));
    vecs.push_back(rd(12'h000, 'h81, 32'h00, 0));
    vecs.push_back(idle('h01, 1));
    vecs.push_back(rd(12'h000, 'h01, 32'h80, 1));
    vecs.push_back(wr(12'h000, 4'hF, 32'h80, 'h01, 0));
    // Inputs high through reset release: priming suppresses edges.
    vecs.push_back(rs('hFF));
    vecs.push_back(rs('hFF));
    vecs.push_back(wr(12'h008, 4'hF, 32'hFF, 'hFF, 0));
    vecs.push_back(wr(12'h004, 4'hF, 32'hFF, 'hFF, 0));
    vecs.push_back(rd(12'h000, 'hFF, 32'h00, 0));
    vecs.push_back(rd(12'h014, 'hFF, 32'hFF, 0));
    vecs.push_back(idle('hF7, 0));
    vecs.push_back(idle('hFF, 1));
    vecs.push_back(rd(12'h000, 'hFF, 32'h08, 1));
    // Edge coinciding with W1C of the same bit keeps the bit set.
    vecs.push_back(wr(12'h000, 4'hF, 32'h08, 'hFB, 0));
    vecs.push_back(idle('hFF, 1));
    vecs.push_back(idle('hFB, 1));
    vecs.push_back(wr(12'h000, 4'hF, 32'h04, 'hFF, 1));
    vecs.push_back(rd(12'h000, 'hFF, 32'h04, 1));
    vecs.push_back(wr(12'h000, 4'hF, 32'h04, 'hFF, 0));
    // Latch while disabled, enable later, INTR_TEST set, byte-lane masking.
    vecs.push_back(wr(12'h004, 4'hF, 32'h00, 'hFF, 0));
    vecs.push_back(idle('hFD, 0));
    vecs.push_back(idle('hFF, 0));
    vecs.push_back(rd(12'h000, 'hFF, 32'h02, 0));
    vecs.push_back(wr(12'h004, 4'hF, 32'h02, 'hFF, 1));
    vecs.push_back(wr(12'h010, 4'hF, 32'h10, 'hFF, 1));
    vecs.push_back(rd(12'h010, 'hFF, 32'h00, 1));
    vecs.push_back(rd(12'h000, 'hFF, 32'h12, 1));
    vecs.push_back(wr(12'h010, 4'h2, 32'h0101, 'hFF, 1));
    vecs.push_back(rd(12'h000, 'hFF, 32'h112, 1));
    vecs.push_back(wr(12'h000, 4'h1, 32'hFFFF, 'hFF, 0));
    vecs.push_back(rd(12'h000, 'hFF, 32'h100, 0));
    // Bus: partial write, unmapped offsets, back-to-back reads, upper bits.
    vecs.push_back(wr(12'h004, 4'h1, 32'hFFFF, 'hFF, 0));
    vecs.push_back(rd(12'h004, 'hFF, 32'hFF, 0));
    vecs.push_back(wr(12'h020, 4'hF, 32'hFFFF_FFFF, 'hFF, 0));
    vecs.push_back(rd(12'h020, 'hFF, 32'h00, 0));
    vecs.push_back(rd(12'h004, 'hFF, 32'hFF, 0));
    vecs.push_back(rd(12'h008, 'hFF, 32'hFF, 0));
    vecs.push_back(wr(12'h00C, 4'hF, 32'hFFFF_FFFF, 'hFF, 0));
    vecs.push_back(rd(12'h00C, 'hFF, 32'hFFFF, 0));
    // Reset with a pending request and irq high: request dropped, irq falls.
    vecs.push_back(wr(12'h004, 4'hF, 32'h100, 'hFF, 1));
    vecs.push_back(mk(1, 1, 0, 12'h000, 4'h0, 32'h0, 'hFF, 32'h0, 0));
    vecs.push_back(rd(12'h000, 'hFF, 32'h00, 0));
    vecs.push_back(rd(12'h004, 'hFF, 32'h00, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand-written: INTR_TEST set / read / clear cycle on each of the low bits.
    apply(wr(12'h004, 4'hF, 32'h0F, 'hFF, 0), 1000);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] bit_val;
      bit_val = 32'h1 << b;
      apply(wr(12'h010, 4'hF, bit_val, 'hFF, 1), 1001 + 3*b);
      apply(rd(12'h000, 'hFF, bit_val, 1), 1002 + 3*b);
      apply(wr(12'h000, 4'hF, bit_val, 'hFF, 0), 1003 + 3*b);
    end
    // Hand-written: bit 15 rise on the upper lane, then disable masks irq.
    apply(wr(12'h008, 4'hF, 32'h8000, 'h00FF, 0), 1100);
    apply(wr(12'h004, 4'hF, 32'h8000, 'h00FF, 0), 1101);
    apply(idle('h80FF, 1), 1102);
    apply(wr(12'h004, 4'h2, 32'h0000, 'h80FF, 0), 1103);
    apply(rd(12'h000, 'h80FF, 32'h8000, 0), 1104);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
